// File: rtl/sub_32_pipe_if.sv
`default_nettype none
// =====================================================================
// sub_32_pipe_if : operand-issue / result-writeback bundle for sub_32_pipe
// Revision 1.0
// =====================================================================
interface sub_32_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             bo;
  logic             ovf;
  logic             zf;

  modport master (
    output in_valid, A, B, bi, out_ready,
    input  in_ready, out_valid, D, bo, ovf, zf
  );

  modport slave (
    input  in_valid, A, B, bi, out_ready,
    output in_ready, out_valid, D, bo, ovf, zf
  );
endinterface
`default_nettype wire

// File: rtl/sub_32_pipe.sv
`default_nettype none
// =====================================================================
// sub_32_pipe : two-stage pipelined subtractor D = A - B - bi
// Revision 1.0
// =====================================================================
module sub_32_pipe #(
  parameter int WIDTH = 32,
  parameter int GRP   = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  sub_32_pipe_if.slave  bus
);

  localparam int H  = WIDTH / 2;
  localparam int NG = H / GRP;

  // Adds a + nb + cin over one half-word; group G/P picks each group's carry-in.
  function automatic logic [H:0] la_add(input logic [H-1:0] a,
                                        input logic [H-1:0] nb,
                                        input logic         cin);
    logic [H-1:0] g;
    logic [H-1:0] p;
    logic [H-1:0] s;
    logic [NG:0]  cg;
    logic         gg;
    logic         pg;
    logic         c;
    g     = a & nb;
    p     = a ^ nb;
    s     = '0;
    cg    = '0;
    cg[0] = cin;
    for (int k = 0; k < NG; k++) begin
      gg = 1'b0;
      pg = 1'b1;
      for (int j = 0; j < GRP; j++) begin
        gg = g[k*GRP+j] | (p[k*GRP+j] & gg);
        pg = pg & p[k*GRP+j];
      end
      cg[k+1] = gg | (pg & cg[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c = cg[k];
      for (int j = 0; j < GRP; j++) begin
        s[k*GRP+j] = p[k*GRP+j] ^ c;
        c          = g[k*GRP+j] | (p[k*GRP+j] & c);
      end
    end
    return {cg[NG], s};
  endfunction

  logic         s1_valid_q, s1_valid_d;
  logic         s2_valid_q, s2_valid_d;
  logic         s1_adv, s2_adv, s1_load, s2_load;

  logic [H-1:0] lo_diff_q;
  logic         brw_q;
  logic         lo_zero_q;
  logic [H-1:0] a_hi_q;
  logic [H-1:0] b_hi_q;

  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             ovf_q;
  logic             zf_q;

  logic [H:0]   lo_sum;
  logic [H:0]   hi_sum;
  logic         ovf_d;

  always_comb begin
    s2_adv     = ~s2_valid_q | bus.out_ready;
    s1_adv     = ~s1_valid_q | s2_adv;
    s1_load    = bus.in_valid & s1_adv;
    s2_load    = s1_valid_q & s2_adv;
    s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q   : s2_valid_q;
  end

  // Subtraction as A + ~B + ~bi; a borrow is the inverse of the carry.
  always_comb begin
    lo_sum = la_add(bus.A[H-1:0], ~bus.B[H-1:0], ~bus.bi);
    hi_sum = la_add(a_hi_q, ~b_hi_q, ~brw_q);
    ovf_d  = (a_hi_q[H-1] != b_hi_q[H-1]) && (hi_sum[H-1] != a_hi_q[H-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      lo_diff_q  <= '0;
      brw_q      <= 1'b0;
      lo_zero_q  <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        lo_diff_q <= lo_sum[H-1:0];
        brw_q     <= ~lo_sum[H];
        lo_zero_q <= (lo_sum[H-1:0] == '0);
        a_hi_q    <= bus.A[WIDTH-1:H];
        b_hi_q    <= bus.B[WIDTH-1:H];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      d_q        <= '0;
      bo_q       <= 1'b0;
      ovf_q      <= 1'b0;
      zf_q       <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        d_q   <= {hi_sum[H-1:0], lo_diff_q};
        bo_q  <= ~hi_sum[H];
        ovf_q <= ovf_d;
        zf_q  <= lo_zero_q & (hi_sum[H-1:0] == '0);
      end
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.D         = d_q;
  assign bus.bo        = bo_q;
  assign bus.ovf       = ovf_q;
  assign bus.zf        = zf_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_32_pipe.sv
`default_nettype none
// =====================================================================
// tb_sub_32_pipe : directed and random checks of sub_32_pipe against a
// queue-based arithmetic reference. Revision 1.0
// =====================================================================
module tb_sub_32_pipe;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ovf;
    logic        zf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  bit   rnd_ready = 0;
  exp_t q[$];
  int   pop_cyc[$];

  sub_32_pipe_if #(.WIDTH(32)) bus ();

  sub_32_pipe #(.WIDTH(32), .GRP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi_);
    exp_t        e;
    logic [32:0] t;
    t     = {1'b0, a} - {1'b0, b} - {32'd0, bi_};
    e.d   = t[31:0];
    e.bo  = t[32];
    e.ovf = (a[31] != b[31]) && (e.d[31] != a[31]);
    e.zf  = (e.d == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Output scoreboard: every cycle with out_valid must show the oldest pending result.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", {63'd0, bus.out_valid}, 64'd0);
        end else begin
          chk("result", {29'd0, bus.D, bus.bo, bus.ovf, bus.zf},
              {29'd0, q[0].d, q[0].bo, q[0].ovf, q[0].zf});
          if (bus.out_ready) begin
            void'(q.pop_front());
            pop_cyc.push_back(cyc);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.A, bus.B, bus.bi));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bi_);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.bi       = bi_;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      w++;
    end
    chk("accept", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic bi_, input logic [31:0] ed, input logic ebo,
                          input logic eovf, input logic ezf);
    send(a, b, bi_);
    chk({tag, "_s1"}, {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    chk(tag, {28'd0, bus.out_valid, bus.D, bus.bo, bus.ovf, bus.zf},
        {28'd0, 1'b1, ed, ebo, eovf, ezf});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.bi        = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_state", {59'd0, bus.out_valid, bus.D == 32'd0, bus.bo, bus.ovf, bus.zf},
        {59'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    idle(2);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Directed arithmetic and boundaries
    directed("basic",    32'd5,          32'd3, 1'b0, 32'd2,          1'b0, 1'b0, 1'b0);
    directed("half_brw", 32'h0001_0000,  32'd1, 1'b0, 32'h0000_FFFF,  1'b0, 1'b0, 1'b0);
    directed("ovf",      32'h8000_0000,  32'd1, 1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0);
    directed("all_brw",  32'd0,          32'd0, 1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);
    directed("equal",    32'h1234_5678,  32'h1234_5678, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1);
    directed("lt_bi",    32'd7,          32'd7, 1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);
    idle(3);

    // Back-to-back stream of 8 with out_ready held high
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
    idle(4);
    chk("stream_count", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8) chk("stream_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    // Backpressure: two accepts fill the pipe, then in_ready must stay low
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_1111, 1'b0);
    send(32'h0000_0001, 32'h0000_0002, 1'b0);
    bus.in_valid = 1'b1;
    bus.A        = 32'hFFFF_0000;
    bus.B        = 32'h0000_FFFF;
    bus.bi       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    idle(4);
    chk("stall_drain", {63'd0, bus.out_valid}, 64'd0);
    chk("stall_no_loss", 64'(q.size()), 64'd0);

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(32'd100, 32'd1, 1'b0);
    send(32'd200, 32'd2, 1'b0);
    chk("full_before_rst", {63'd0, bus.out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale", {63'd0, bus.out_valid}, 64'd0);
    end
    @(posedge clk); #1;

    // Random operands with random backpressure and gaps
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra ^ 32'h0001_0000;
      send(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rnd_ready     = 1'b0;
    bus.out_ready = 1'b1;
    idle(5);
    chk("random_drain", 64'(q.size()), 64'd0);
    chk("random_idle", {63'd0, bus.out_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
